// File: rtl/alu_mc.sv
// alu_mc: registered, handshaked ALU with an iterative shift-add multiplier.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   operands and opcode valid
//   in_ready   block can accept this cycle
//   F          4-bit opcode
//   A, B       WIDTH-bit two's-complement operands
//   out_valid  result registers hold an unconsumed result
//   out_ready  consumer takes the result this cycle
//   Y          registered result
//   zero       Y == 0 (registered alongside Y)
//   OF         overflow (ADD/SUB signed overflow, MUL high-half nonzero)
//   cout       carry out of the adder (ADD/SUB only)
//   err        a reserved opcode was executed
//
// Single-cycle ops complete on the accept edge. MUL takes WIDTH BUSY cycles,
// one shift-add step per cycle, and writes the result on the last one.
module alu_mc #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       F,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Y,
   output logic             zero,
   output logic             OF,
   output logic             cout,
   output logic             err
);

   localparam int unsigned SW = $clog2(WIDTH);
   localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t state, state_nx;

   logic                 accept;
   logic                 mul_go;
   logic                 last;

   logic [2*WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]     mplier;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_nx;
   logic [SW-1:0]        cnt;

   logic [WIDTH-1:0]     bx;
   logic [WIDTH:0]       sum;
   logic                 ovf;
   logic [SW-1:0]        amt;
   logic [WIDTH-1:0]     r_y;
   logic                 r_of;
   logic                 r_co;
   logic                 r_err;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Handshake and next state
   always_comb begin
      in_ready = 1'b0;
      state_nx = state;
      accept   = 1'b0;
      mul_go   = 1'b0;
      last     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !reset && (!out_valid || out_ready);
            accept   = in_valid && in_ready;
            mul_go   = accept && (F == 4'b1000);
            if (mul_go) begin
               state_nx = BUSY;
            end
         end
         BUSY: begin
            last = (cnt == LAST);
            if (last) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Single-cycle datapath. SUB and SLT share the inverted-B adder path
   // (F[2] both selects ~B and supplies the carry-in).
   always_comb begin
      bx    = F[2] ? ~B : B;
      sum   = {1'b0, A} + {1'b0, bx} + {{WIDTH{1'b0}}, F[2]};
      ovf   = (A[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      amt   = B[SW-1:0];
      r_y   = '0;
      r_of  = 1'b0;
      r_co  = 1'b0;
      r_err = 1'b0;
      case (F)
         4'b0000: r_y = A & B;
         4'b0001: r_y = A | B;
         4'b0010,
         4'b0110: begin
            r_y  = sum[WIDTH-1:0];
            r_of = ovf;
            r_co = sum[WIDTH];
         end
         4'b0100: r_y = A & ~B;
         4'b0101: r_y = A | ~B;
         // Sign of A-B corrected by overflow gives the true signed less-than.
         4'b0111: r_y = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
         4'b1000: r_y = '0;
         4'b1001: r_y = A << amt;
         4'b1010: r_y = A >> amt;
         4'b1011: r_y = $signed(A) >>> amt;
         default: r_err = 1'b1;
      endcase
   end

   assign acc_nx = acc + (mplier[0] ? mcand : '0);

   // Multiplier registers and output register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         Y         <= '0;
         zero      <= 1'b0;
         OF        <= 1'b0;
         cout      <= 1'b0;
         err       <= 1'b0;
      end else begin
         if (mul_go) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
         end else if (state == BUSY) begin
            acc    <= acc_nx;
            mplier <= mplier >> 1;
            mcand  <= mcand << 1;
            cnt    <= cnt + SW'(1);
         end

         // A MUL accept falls through to the consume branch: accepting
         // requires the old result to be taken in the same edge.
         if (accept && !mul_go) begin
            Y         <= r_y;
            zero      <= (r_y == '0);
            OF        <= r_of;
            cout      <= r_co;
            err       <= r_err;
            out_valid <= 1'b1;
         end else if (last) begin
            Y         <= acc_nx[WIDTH-1:0];
            zero      <= (acc_nx[WIDTH-1:0] == '0);
            OF        <= |acc_nx[2*WIDTH-1:WIDTH];
            cout      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized and directed self-checking bench for alu_mc
// (WIDTH=32) against a behavioural arithmetic reference model.
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  F = '0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] Y;
   logic        zero;
   logic        OF;
   logic        cout;
   logic        err;

   int unsigned nchk = 0;
   int unsigned nerr = 0;

   alu_mc #(.WIDTH(32)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .F(F),
      .A(A),
      .B(B),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .Y(Y),
      .zero(zero),
      .OF(OF),
      .cout(cout),
      .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the operation definitions.
   function automatic void model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] y, output logic of, output logic co,
                                 output logic er);
      longint            sa, sb, r;
      longint unsigned   u;
      logic [63:0]       p;
      logic [4:0]        sh;
      longint            maxs, mins;
      maxs = 64'sd2147483647;
      mins = -64'sd2147483648;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = b[4:0];
      y = '0; of = 1'b0; co = 1'b0; er = 1'b0;
      case (f)
         4'd0: y = a & b;
         4'd1: y = a | b;
         4'd2: begin
            r  = sa + sb;
            u  = longint'(a) + longint'(b);
            y  = a + b;
            of = (r > maxs) || (r < mins);
            co = (u >= 64'h1_0000_0000);
         end
         4'd4: y = a & ~b;
         4'd5: y = a | ~b;
         4'd6: begin
            r  = sa - sb;
            y  = a - b;
            of = (r > maxs) || (r < mins);
            co = (a >= b);
         end
         4'd7: y = (sa < sb) ? 32'd1 : 32'd0;
         4'd8: begin
            p  = {32'b0, a} * {32'b0, b};
            y  = p[31:0];
            of = (p[63:32] != 0);
         end
         4'd9:  y = a << sh;
         4'd10: y = a >> sh;
         4'd11: y = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
         default: er = 1'b1;
      endcase
   endfunction

   // Present one op with out_ready high, wait for its result, check everything.
   task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ey;
      logic        eof, eco, eer;
      int unsigned waited, lat, busy, exp_lat;
      bit          acc_ok;
      model(f, a, b, ey, eof, eco, eer);
      exp_lat = (f == 4'd8) ? 32 : 0;
      F = f; A = a; B = b; in_valid = 1'b1;
      waited = 0; acc_ok = 1'b0;
      while (!acc_ok && waited < 200) begin
         if (in_ready) acc_ok = 1'b1;
         @(posedge clk); #1;
         if (!acc_ok) waited++;
      end
      in_valid = 1'b0;
      F = 4'($urandom); A = $urandom; B = $urandom;
      chk("accept", 32'(acc_ok), 32'd1);
      lat = 0; busy = 0;
      while (!out_valid && lat < 200) begin
         if (!in_ready) busy++;
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("lat f=%0d", f), lat, exp_lat);
      chk($sformatf("busy f=%0d", f), busy, exp_lat);
      chk($sformatf("Y f=%0d a=%h b=%h", f, a, b), Y, ey);
      chk($sformatf("zero f=%0d", f), 32'(zero), 32'(ey == 0));
      chk($sformatf("OF f=%0d a=%h b=%h", f, a, b), 32'(OF), 32'(eof));
      chk($sformatf("cout f=%0d a=%h b=%h", f, a, b), 32'(cout), 32'(eco));
      chk($sformatf("err f=%0d", f), 32'(err), 32'(eer));
   endtask

   function automatic logic [31:0] rnd_val();
      logic [31:0] c [5];
      c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'hFFFF_FFFF;
      c[3] = 32'h7FFF_FFFF; c[4] = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   initial begin
      int unsigned stalls, seen;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst in_ready", 32'(in_ready), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst Y", Y, 32'd0);
      chk("rst zero", 32'(zero), 32'd0);
      chk("rst flags", {29'b0, OF, cout, err}, 32'd0);
      reset = 1'b0;
      #1;
      chk("rel in_ready", 32'(in_ready), 32'd1);

      // Overflow and subtract/compare
      run_op(4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
      chk("add ovf Y", Y, 32'h8000_0000);
      chk("add ovf OF", 32'(OF), 32'd1);
      run_op(4'd6, 32'd5, 32'd5);
      chk("sub eq cout", 32'(cout), 32'd1);
      chk("sub eq zero", 32'(zero), 32'd1);
      run_op(4'd7, 32'h8000_0000, 32'h7FFF_FFFF);
      chk("slt Y", Y, 32'd1);

      // Multiply
      run_op(4'd8, 32'h0001_0000, 32'h0001_0000);
      chk("mul hi OF", 32'(OF), 32'd1);
      chk("mul hi zero", 32'(zero), 32'd1);
      run_op(4'd8, 32'd7, 32'd6);
      chk("mul 42", Y, 32'd42);

      // Shifts and reserved opcode
      run_op(4'd11, 32'h8000_0000, 32'h0000_003F);
      chk("sra Y", Y, 32'hFFFF_FFFF);
      run_op(4'd9, 32'd1, 32'd4);
      chk("sll Y", Y, 32'h10);
      run_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
      chk("rsv err", 32'(err), 32'd1);
      run_op(4'd0, 32'hFFFF_0000, 32'h0F0F_0F0F);
      chk("err cleared", 32'(err), 32'd0);

      // Reset mid-MUL
      F = 4'd8; A = 32'hDEAD_BEEF; B = 32'h0000_0F0F; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst Y", Y, 32'd0);
      chk("midrst in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      F = 4'd2; A = 32'd2; B = 32'd3; in_valid = 1'b1;
      #1;
      chk("postrst in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("postrst out_valid", 32'(out_valid), 32'd1);
      chk("postrst Y", Y, 32'd5);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("no stale mul", seen, 32'd0);

      // Backpressure
      out_ready = 1'b0;
      F = 4'd0; A = 32'hF0F0_F0F0; B = 32'hFF00_FF00; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp first valid", 32'(out_valid), 32'd1);
      chk("bp first Y", Y, 32'hF000_F000);
      F = 4'd1; A = 32'd1; B = 32'd2;
      stalls = 0;
      repeat (5) begin
         if (in_ready) stalls++;
         @(posedge clk); #1;
      end
      chk("bp held ready", stalls, 32'd0);
      chk("bp held Y", Y, 32'hF000_F000);
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("bp second valid", 32'(out_valid), 32'd1);
      chk("bp second Y", Y, 32'd3);
      repeat (3) @(posedge clk);
      #1;
      chk("bp second hold", Y, 32'd3);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp drained", 32'(out_valid), 32'd0);
      chk("bp Y kept", Y, 32'd3);

      // Randomized ops, back-to-back with out_ready high
      for (int i = 0; i < 300; i++) begin
         run_op(4'($urandom_range(0, 15)), rnd_val(), rnd_val());
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, handshaked successor to the lab-4 combinational 32-bit ALU. It registers its result and flags and extends the opcode to four bits, adding shifts and an iterative shift-add multiplier. It also adds a valid/ready handshake on both sides so that the datapath and the file-driven benches can stall it. It sits between the operand-fetch stage and writeback.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 4
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and opcode valid
- in_ready  out  1  block can accept this cycle
- F  in  4  opcode (see Operation)
- A  in  WIDTH  operand A, two's complement
- B  in  WIDTH  operand B, two's complement
- out_valid  out  1  result registers hold an unconsumed result
- out_ready  in  1  consumer takes result this cycle
- Y  out  WIDTH  result
- zero  out  1  Y == 0
- OF  out  1  overflow (per op)
- cout  out  1  carry out of adder (ADD/SUB only, else 0)
- err  out  1  reserved opcode was executed

## Operation
- Opcodes with F[3]=0 keep the lab-4 encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 reserved
  - 0100 A&~B
  - 0101 A|~B
  - 0110 SUB (A+~B+1)
  - 0111 SLT
- Opcodes with F[3]=1:
  - 1000 MUL (low WIDTH bits of unsigned A×B)
  - 1001 SLL
  - 1010 SRL
  - 1011 SRA
  - 1100–1111 reserved
- Shift amount is B[clog2(WIDTH)-1:0]; the upper bits of B are ignored.
- ADD/SUB:
  - OF = signed overflow, i.e. operand signs equal (after inverting B for SUB) and result sign differs.
  - cout = carry out of bit WIDTH-1.
- SLT: Y = 1 if A < B signed, using overflow-corrected comparison, else 0; OF=0.
- MUL: OF = 1 if any bit of the full 2·WIDTH product above WIDTH-1 is set.
- Logic and shift ops: OF=0, cout=0.
- Reserved opcodes: Y=0, zero=1, OF=0, cout=0, err=1.
- err=0 for every defined opcode.
- zero always reflects the registered Y.
- State machine:
  - IDLE: in_ready = !out_valid || out_ready.
    - Single-cycle op on accept (in_valid && in_ready): result and flags registered, out_valid=1, stay in IDLE.
    - MUL on accept: latch A, B; clear the 2·WIDTH accumulator and counter; go to BUSY.
  - BUSY: in_ready=0. Each cycle:
    - if multiplier LSB is 1, add the shifted multiplicand to the accumulator;
    - shift the multiplier right and the multiplicand left;
    - increment the counter.
    - On the WIDTH-th BUSY cycle, write Y, flags and out_valid=1, then go to IDLE.
- The output register is never overwritten while out_valid && !out_ready.
- Because accept requires the output register to be free, out_valid=0 throughout BUSY.
- Consume: out_valid && out_ready with no new load clears out_valid. Y and flags hold their last values.
- Simultaneous consume and accept: the new result replaces the old in the same edge, and out_valid stays 1.
- Operands are sampled only at accept, so A, B and F may change freely afterwards.

## Timing
- Reset (asynchronous, mid-operation included):
  - state=IDLE; MUL operation aborted, accumulator and counter cleared.
  - out_valid=0, Y=0, zero=0, OF=0, cout=0, err=0.
  - in_ready=0 while reset is high; in_ready=1 in the first cycle after release.
- Single-cycle op latency: result visible in the cycle after the accept edge.
- Throughput: 1 op/cycle when out_ready=1.
- MUL latency: out_valid rises exactly WIDTH cycles after the accept edge.
- MUL occupancy: in_ready=0 for WIDTH cycles.
- Next op may be accepted in the cycle out_valid rises for the MUL result, provided out_ready=1.
- in_ready is combinational from state, out_valid and out_ready. There is no combinational path from in_valid, A, B or F to any output.

## Test plan
- Overflow, WIDTH=32:
  - Stimulus: ADD A=0x7FFFFFFF, B=0x00000001.
  - Required: one cycle later Y=0x80000000, OF=1, zero=0, cout=0, out_valid=1.
- Subtract/compare:
  - SUB A=5, B=5 → Y=0, zero=1, OF=0, cout=1.
  - Then SLT A=0x80000000, B=0x7FFFFFFF → Y=1, OF=0.
- Multiply:
  - Stimulus: MUL A=0x00010000, B=0x00010000.
  - Required: in_ready=0 for 32 cycles; out_valid rises exactly 32 cycles after accept; Y=0, zero=1, OF=1.
  - Also: MUL 7×6 → Y=42, OF=0.
- Backpressure:
  - Stimulus: out_ready=0; AND 0xF0F0F0F0,0xFF00FF00 then OR 1,2 presented back-to-back.
  - Required: second op is not accepted until out_ready pulses; results appear in order, Y=0xF000F000 then Y=3, with no loss or duplication.
- Reset mid-MUL:
  - Stimulus: assert reset 10 cycles into a MUL.
  - Required: out_valid=0 and Y=0 immediately; after release a new ADD 2+3 is accepted in the first cycle and gives Y=5.
- Shifts and reserved opcode:
  - SRA A=0x80000000, B=0x0000003F (amount 31) → Y=0xFFFFFFFF.
  - SLL A=1, B=4 → Y=0x10.
  - F=1111 → err=1, Y=0, zero=1; the next defined op clears err.
